// File: rtl/step_sequencer.sv
// step_sequencer: walks a step index through NUM_STEPS positions, pacing each
// free-run advance with a one-shot interval timer (start request out, done
// pulse in). Also supports single-step and clear.
module step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int LOOP      = 1,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             CLR,
    input  logic             TIMER_PULSE,
    output logic             TIMER_START,
    output logic [IDX_W-1:0] STEP_IDX,
    output logic             STEP_STROBE,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STEPS - 1);
    localparam bit               WRAP = (LOOP != 0);

    state_t           state;
    // Set when a timed advance happens with RUN high: the strobe cycle is
    // spent in IDLE so the next start request lands one cycle after it.
    logic             rearm;
    logic             at_end;
    logic             stop_here;
    logic [IDX_W-1:0] idx_next;

    // Advance rule: increment, wrap when looping, or hold at the end.
    always_comb begin
        at_end    = (STEP_IDX == LAST);
        stop_here = at_end && !WRAP;
        idx_next  = at_end ? '0 : STEP_IDX + IDX_W'(1);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            rearm       <= 1'b0;
            STEP_IDX    <= '0;
            TIMER_START <= 1'b0;
            STEP_STROBE <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            TIMER_START <= 1'b0;
            STEP_STROBE <= 1'b0;
            case (state)
                S_IDLE: begin
                    rearm <= 1'b0;
                    if (CLR) begin
                        STEP_IDX <= '0;
                        DONE     <= 1'b0;
                    end else if ((RUN || rearm) && !DONE) begin
                        state       <= S_ARM;
                        TIMER_START <= 1'b1;
                    end else if (STEP && !RUN) begin
                        if (stop_here) begin
                            DONE <= 1'b1;
                        end else begin
                            STEP_IDX    <= idx_next;
                            STEP_STROBE <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    state <= S_WAIT;
                    BUSY  <= 1'b1;
                    if (CLR) begin
                        STEP_IDX <= '0;
                        DONE     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (CLR) begin
                        // A coincident pulse is swallowed by the clear.
                        STEP_IDX <= '0;
                        DONE     <= 1'b0;
                        if (TIMER_PULSE) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (TIMER_PULSE) begin
                        BUSY <= 1'b0;
                        if (stop_here) begin
                            DONE  <= 1'b1;
                            state <= S_HALT;
                        end else begin
                            STEP_IDX    <= idx_next;
                            STEP_STROBE <= 1'b1;
                            state       <= S_IDLE;
                            rearm       <= RUN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (TIMER_PULSE) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (CLR) begin
                        state    <= S_IDLE;
                        STEP_IDX <= '0;
                        DONE     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: three instances (4 steps looping,
// 4 steps stopping, 8 steps looping) share control inputs; each has its own
// interval-timer model that pulses 5 cycles after its start request.
module tb_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, step, clr, man_pulse, tim_en;

    logic       st0, st1, st2;
    logic       tp0, tp1, tp2;
    logic       sb0, sb1, sb2;
    logic       bs0, bs1, bs2;
    logic       dn0, dn1, dn2;
    logic [1:0] ix0, ix1;
    logic [2:0] ix2;

    int cnt0, cnt1, cnt2;
    int total = 0;
    int bad   = 0;
    int nst, nsb;
    bit seen;

    // Timer models: load 5 on a start request, pulse while the count is 1.
    always @(posedge clk) begin
        if (rst) begin
            cnt0 <= 0; cnt1 <= 0; cnt2 <= 0;
        end else begin
            cnt0 <= st0 ? 5 : (cnt0 != 0 ? cnt0 - 1 : 0);
            cnt1 <= st1 ? 5 : (cnt1 != 0 ? cnt1 - 1 : 0);
            cnt2 <= st2 ? 5 : (cnt2 != 0 ? cnt2 - 1 : 0);
        end
    end
    assign tp0 = (tim_en && cnt0 == 1) || man_pulse;
    assign tp1 = (tim_en && cnt1 == 1) || man_pulse;
    assign tp2 = (tim_en && cnt2 == 1) || man_pulse;

    step_sequencer #(.NUM_STEPS(4), .LOOP(1)) u4 (
        .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .CLR(clr),
        .TIMER_PULSE(tp0), .TIMER_START(st0), .STEP_IDX(ix0),
        .STEP_STROBE(sb0), .BUSY(bs0), .DONE(dn0));

    step_sequencer #(.NUM_STEPS(4), .LOOP(0)) u4h (
        .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .CLR(clr),
        .TIMER_PULSE(tp1), .TIMER_START(st1), .STEP_IDX(ix1),
        .STEP_STROBE(sb1), .BUSY(bs1), .DONE(dn1));

    step_sequencer #(.NUM_STEPS(8), .LOOP(1)) u8 (
        .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .CLR(clr),
        .TIMER_PULSE(tp2), .TIMER_START(st2), .STEP_IDX(ix2),
        .STEP_STROBE(sb2), .BUSY(bs2), .DONE(dn2));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; on return the next edge is cycle 1.
    task automatic do_rst();
        rst = 1'b1; run = 1'b0; step = 1'b0; clr = 1'b0;
        man_pulse = 1'b0; tim_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // ---- reset state, then reset mid-WAIT at index 5 (8 steps) ----
        do_rst();
        chk("rst_idx", ix2, 0);
        chk("rst_start", st2, 0);
        chk("rst_strobe", sb2, 0);
        chk("rst_busy", bs2, 0);
        chk("rst_done", dn2, 0);
        for (int k = 0; k < 5; k++) begin
            step = 1'b1; tick();
            step = 1'b0; tick();
        end
        chk("pre_idx5", ix2, 5);
        run = 1'b1; tick();
        chk("pre_arm", st2, 1);
        run = 1'b0; tick();
        chk("pre_wait_busy", bs2, 1);
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        chk("midrst_idx", ix2, 0);
        chk("midrst_start", st2, 0);
        chk("midrst_strobe", sb2, 0);
        chk("midrst_busy", bs2, 0);
        chk("midrst_done", dn2, 0);
        nsb = 0;
        for (int k = 0; k < 8; k++) begin tick(); nsb += int'(sb2) + int'(st2); end
        chk("midrst_quiet", nsb, 0);
        man_pulse = 1'b1; tick();
        man_pulse = 1'b0;
        chk("late_pulse_strobe", sb2, 0);
        chk("late_pulse_idx", ix2, 0);

        // ---- free-run, 4 steps, looping ----
        do_rst();
        run = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            tick();
            chk($sformatf("fr_start_c%0d", c), st0, (c % 7 == 1) ? 1 : 0);
            chk($sformatf("fr_strobe_c%0d", c), sb0, (c % 7 == 0) ? 1 : 0);
            chk($sformatf("fr_busy_c%0d", c), bs0, (c % 7 >= 2) ? 1 : 0);
            chk($sformatf("fr_idx_c%0d", c), ix0, (c / 7) % 4);
        end

        // ---- free-run, 4 steps, stop at end ----
        do_rst();
        run = 1'b1;
        nst = 0; nsb = 0;
        for (int c = 1; c <= 78; c++) begin
            tick();
            nst += int'(st1);
            nsb += int'(sb1);
            if (c == 21) begin
                chk("halt_idx3", ix1, 3);
                chk("halt_notdone", dn1, 0);
            end
            if (c == 28) begin
                chk("halt_done", dn1, 1);
                chk("halt_nostrobe", sb1, 0);
                chk("halt_idx_hold", ix1, 3);
            end
        end
        chk("halt_starts", nst, 4);
        chk("halt_strobes", nsb, 3);
        chk("halt_done_held", dn1, 1);
        clr = 1'b1; tick();
        clr = 1'b0;
        chk("halt_clr_idx", ix1, 0);
        chk("halt_clr_done", dn1, 0);
        chk("halt_clr_start", st1, 0);
        tick();
        chk("halt_rearm", st1, 1);

        // ---- RUN dropped during WAIT ----
        do_rst();
        run = 1'b1; tick();
        chk("drop_start", st0, 1);
        tick(); tick();
        run = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = sb0; end
        chk("drop_strobe_seen", seen, 1);
        chk("drop_idx", ix0, 1);
        nst = 0;
        for (int k = 0; k < 20; k++) begin tick(); nst += int'(st0); end
        chk("drop_no_restart", nst, 0);
        chk("drop_idle_busy", bs0, 0);
        chk("drop_idx_hold", ix0, 1);

        // ---- single-step, 4 steps, looping ----
        do_rst();
        nst = 0;
        for (int k = 0; k < 5; k++) begin
            step = 1'b1; tick();
            step = 1'b0;
            nst += int'(st0);
            chk($sformatf("ss_strobe%0d", k), sb0, 1);
            chk($sformatf("ss_idx%0d", k), ix0, (k + 1) % 4);
            tick();
            nst += int'(st0);
            chk($sformatf("ss_gap%0d", k), sb0, 0);
        end
        chk("ss_nostart", nst, 0);
        run = 1'b1; tick();
        run = 1'b0;
        chk("ss_arm", st0, 1);
        tick();
        step = 1'b1; tick();
        step = 1'b0;
        chk("ss_wait_step_idx", ix0, 1);
        chk("ss_wait_step_strobe", sb0, 0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = sb0; end
        chk("ss_timed_seen", seen, 1);
        chk("ss_timed_idx", ix0, 2);

        // ---- CLR coincident with the pulse in WAIT ----
        do_rst();
        tim_en = 1'b0;
        step = 1'b1; tick(); tick();
        step = 1'b0;
        chk("cp_idx2", ix0, 2);
        run = 1'b1; tick();
        run = 1'b0;
        tick(); tick();
        chk("cp_in_wait", bs0, 1);
        clr = 1'b1; man_pulse = 1'b1; tick();
        clr = 1'b0; man_pulse = 1'b0;
        chk("cp_idx", ix0, 0);
        chk("cp_strobe", sb0, 0);
        chk("cp_busy", bs0, 0);
        tick();
        chk("cp_idle_busy", bs0, 0);
        chk("cp_idle_start", st0, 0);

        // ---- CLR mid-WAIT drains the outstanding interval ----
        do_rst();
        step = 1'b1; tick();
        step = 1'b0;
        run = 1'b1; tick();
        run = 1'b0;
        chk("dr_arm", st0, 1);
        tick(); tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        chk("dr_idx", ix0, 0);
        chk("dr_busy0", bs0, 1);
        tick();
        chk("dr_busy1", bs0, 1);
        tick();
        chk("dr_busy2", bs0, 1);
        tick();
        chk("dr_end_busy", bs0, 0);
        chk("dr_end_idx", ix0, 0);
        chk("dr_end_strobe", sb0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
